// File: rtl/neuron_mac_sequencer.sv
// rtl/neuron_mac_sequencer.sv - term sequencer driving an 8-bit signed x*weight+bias accumulate unit
module neuron_mac_sequencer #(
  parameter int DW        = 8,
  parameter int SETUP_CYC = 2,
  parameter int MAX_TERMS = 16,
  localparam int CW       = $clog2(MAX_TERMS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_x,
  input  logic signed [DW-1:0] in_w,
  input  logic signed [DW-1:0] in_bias,
  input  logic                 in_last,
  output logic                 acc_clr,
  output logic                 acc_en,
  output logic signed [DW-1:0] acc_x,
  output logic signed [DW-1:0] acc_w,
  output logic signed [DW-1:0] acc_bias,
  input  logic signed [DW-1:0] acc_accu,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic [CW-1:0]        out_terms,
  output logic                 out_ovf
);

  // Setup countdown only needs to reach SETUP_CYC-1.
  localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCEPT,
    S_SETUP,
    S_FIRE,
    S_SETTLE,
    S_OUT
  } state_t;

  state_t                r_state;
  logic                  r_in_ready;
  logic                  r_acc_clr;
  logic                  r_acc_en;
  logic signed [DW-1:0]  r_acc_x;
  logic signed [DW-1:0]  r_acc_w;
  logic signed [DW-1:0]  r_acc_bias;
  logic                  r_out_valid;
  logic signed [DW-1:0]  r_out_data;
  logic [CW-1:0]         r_out_terms;
  logic                  r_ovf;
  logic [CW-1:0]         r_cnt;
  logic                  r_first;
  logic                  r_last;
  logic [SW-1:0]         r_setup_cnt;

  logic                  w_in_hs;
  logic                  w_room;

  assign w_in_hs = in_valid && r_in_ready;
  // Once MAX_TERMS terms have been accumulated further terms are swallowed without a strobe.
  assign w_room  = (r_cnt != CW'(MAX_TERMS));

  // Sequencer FSM; every output is registered and set on entry to the state that owns it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_acc_clr   <= 1'b1;
      r_acc_en    <= 1'b0;
      r_acc_x     <= '0;
      r_acc_w     <= '0;
      r_acc_bias  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_terms <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_first     <= 1'b1;
      r_last      <= 1'b0;
      r_setup_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_acc_clr <= 1'b1;
          r_state   <= S_CLEAR;
        end
        S_CLEAR: begin
          r_cnt      <= '0;
          r_first    <= 1'b1;
          r_ovf      <= 1'b0;
          r_acc_clr  <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= S_ACCEPT;
        end
        S_ACCEPT: begin
          if (w_in_hs) begin
            r_in_ready <= 1'b0;
            r_acc_x    <= in_x;
            r_acc_w    <= in_w;
            r_last     <= in_last;
            // Bias rides only with the first term so it is summed once per neuron.
            r_acc_bias <= r_first ? in_bias : '0;
            if (SETUP_CYC <= 1) begin
              r_acc_en <= w_room;
              r_state  <= S_FIRE;
            end else begin
              r_setup_cnt <= SW'(SETUP_CYC - 1);
              r_state     <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (r_setup_cnt <= SW'(1)) begin
            r_acc_en <= w_room;
            r_state  <= S_FIRE;
          end else begin
            r_setup_cnt <= r_setup_cnt - SW'(1);
          end
        end
        S_FIRE: begin
          r_acc_en <= 1'b0;
          r_first  <= 1'b0;
          if (w_room) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_ovf <= 1'b1;
          end
          if (r_last) begin
            r_state <= S_SETTLE;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= S_ACCEPT;
          end
        end
        S_SETTLE: begin
          // accumulate registered the last strobe on the previous edge; its accu is now valid.
          r_out_data  <= acc_accu;
          r_out_terms <= r_cnt;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc_clr   <= 1'b1;
            r_state     <= S_CLEAR;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_acc_en    <= 1'b0;
          r_out_valid <= 1'b0;
          r_acc_clr   <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign acc_clr   = r_acc_clr;
  assign acc_en    = r_acc_en;
  assign acc_x     = r_acc_x;
  assign acc_w     = r_acc_w;
  assign acc_bias  = r_acc_bias;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_terms = r_out_terms;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// tb/tb_neuron_mac_sequencer.sv - directed self-checking bench for neuron_mac_sequencer
module tb_neuron_mac_sequencer;

  // Instance 0: SETUP_CYC=2/MAX_TERMS=16, 1: 2/2, 2: 1/16, 3: 3/16
  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       in_valid_a  [NI];
  logic       in_last_a   [NI];
  logic       out_ready_a [NI];
  logic [7:0] in_x_a      [NI];
  logic [7:0] in_w_a      [NI];
  logic [7:0] in_bias_a   [NI];

  logic       in_ready_a  [NI];
  logic       acc_clr_a   [NI];
  logic       acc_en_a    [NI];
  logic       out_valid_a [NI];
  logic       out_ovf_a   [NI];
  logic [7:0] acc_x_a     [NI];
  logic [7:0] acc_w_a     [NI];
  logic [7:0] acc_bias_a  [NI];
  logic [7:0] out_data_a  [NI];
  logic [7:0] accu_a      [NI];
  logic [4:0] out_terms_a [NI];
  int         en_cnt_a    [NI];
  int         nzb_a       [NI];
  int         stab_viol_a [NI];
  int         ovl_viol_a  [NI];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int SC  = (g == 2) ? 1 : ((g == 3) ? 3 : 2);
    localparam int MT  = (g == 1) ? 2 : 16;
    localparam int CWG = $clog2(MT + 1);

    logic [CWG-1:0] terms;
    logic [7:0]     accu = '0;
    logic [7:0]     px   = '0;
    logic [7:0]     pw   = '0;
    int             scnt = 0;
    int             en_cnt = 0;
    int             nzb  = 0;
    int             sv   = 0;
    int             ov   = 0;
    logic           chg;
    int             cur;

    assign chg = (acc_x_a[g] != px) || (acc_w_a[g] != pw);
    assign cur = chg ? 1 : scnt + 1;

    neuron_mac_sequencer #(.DW(8), .SETUP_CYC(SC), .MAX_TERMS(MT)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in_x      (in_x_a[g]),
      .in_w      (in_w_a[g]),
      .in_bias   (in_bias_a[g]),
      .in_last   (in_last_a[g]),
      .acc_clr   (acc_clr_a[g]),
      .acc_en    (acc_en_a[g]),
      .acc_x     (acc_x_a[g]),
      .acc_w     (acc_w_a[g]),
      .acc_bias  (acc_bias_a[g]),
      .acc_accu  (accu_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .out_data  (out_data_a[g]),
      .out_terms (terms),
      .out_ovf   (out_ovf_a[g])
    );

    assign out_terms_a[g] = 5'(terms);
    assign accu_a[g]      = accu;
    assign en_cnt_a[g]    = en_cnt;
    assign nzb_a[g]       = nzb;
    assign stab_viol_a[g] = sv;
    assign ovl_viol_a[g]  = ov;

    // Model of accumulate plus per-neuron strobe counters and operand-stability monitor.
    always @(posedge clk) begin
      if (acc_clr_a[g]) begin
        accu   <= '0;
        en_cnt <= 0;
        nzb    <= 0;
      end else if (acc_en_a[g]) begin
        accu   <= accu + acc_x_a[g] * acc_w_a[g] + acc_bias_a[g];
        en_cnt <= en_cnt + 1;
        if (acc_bias_a[g] != 8'd0) nzb <= nzb + 1;
      end
      if (acc_en_a[g] && (cur < SC)) sv <= sv + 1;
      if (acc_en_a[g] && acc_clr_a[g]) ov <= ov + 1;
      px   <= acc_x_a[g];
      pw   <= acc_w_a[g];
      scnt <= (cur > 1000) ? 1000 : cur;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int k, input logic [7:0] x, input logic [7:0] w,
                      input logic [7:0] b, input logic last);
    int n = 0;
    in_x_a[k]     = x;
    in_w_a[k]     = w;
    in_bias_a[k]  = b;
    in_last_a[k]  = last;
    in_valid_a[k] = 1'b1;
    while (!in_ready_a[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(in_ready_a[k]), 32'd1);
    @(negedge clk);
    in_valid_a[k] = 1'b0;
    in_x_a[k]     = 8'h5A;
    in_w_a[k]     = 8'hA5;
    in_bias_a[k]  = 8'h77;
    in_last_a[k]  = 1'b0;
  endtask

  task automatic wait_valid(input int k);
    int n = 0;
    while (!out_valid_a[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", 32'(out_valid_a[k]), 32'd1);
  endtask

  task automatic result(input int k, input string tag, input logic [7:0] exp_d,
                        input int exp_t, input logic exp_o, input int exp_en);
    wait_valid(k);
    check({tag, "_data"},  32'(out_data_a[k]),  32'(exp_d));
    check({tag, "_terms"}, 32'(out_terms_a[k]), 32'(exp_t));
    check({tag, "_ovf"},   32'(out_ovf_a[k]),   32'(exp_o));
    check({tag, "_en"},    32'(en_cnt_a[k]),    32'(exp_en));
    out_ready_a[k] = 1'b1;
    @(negedge clk);
    out_ready_a[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < NI; i++) begin
      in_valid_a[i] = 1'b0; in_last_a[i] = 1'b0; out_ready_a[i] = 1'b0;
      in_x_a[i] = '0; in_w_a[i] = '0; in_bias_a[i] = '0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(in_ready_a[0]),  32'd0);
    check("rst_acc_en",    32'(acc_en_a[0]),    32'd0);
    check("rst_acc_clr",   32'(acc_clr_a[0]),   32'd1);
    check("rst_out_valid", 32'(out_valid_a[0]), 32'd0);
    check("rst_ovf",       32'(out_ovf_a[0]),   32'd0);
    check("rst_ops", 32'({acc_x_a[0], acc_w_a[0], acc_bias_a[0]}), 32'd0);
    check("rst_out", 32'({out_data_a[0], out_terms_a[0]}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_clr", 32'({acc_clr_a[0], in_ready_a[0]}), 32'b10);

    // Single-term neuron: 5*2 + 1
    send(0, 8'd5, 8'd2, 8'd1, 1'b1);
    result(0, "one", 8'd11, 1, 1'b0, 1);

    // Three terms with input gaps: (5*2+2) + 3*-4 + -1*-1 = 1, bias on pulse 1 only
    send(0, 8'd5, 8'd2, 8'd2, 1'b0);
    repeat (3) @(negedge clk);
    send(0, 8'd3, 8'hFC, 8'd2, 1'b0);
    repeat (5) @(negedge clk);
    send(0, 8'hFF, 8'hFF, 8'd2, 1'b1);
    wait_valid(0);
    check("three_nzbias", 32'(nzb_a[0]), 32'd1);
    result(0, "three", 8'd1, 3, 1'b0, 3);

    // Truncation: 100*2 wraps to -56
    send(0, 8'd100, 8'd2, 8'd0, 1'b1);
    result(0, "wrap", 8'hC8, 1, 1'b0, 1);

    // Backpressure: 3*3 - 1 = 8 held for 10 cycles
    send(0, 8'd3, 8'd3, 8'hFF, 1'b1);
    wait_valid(0);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", 32'({out_valid_a[0], in_ready_a[0], out_data_a[0]}), 32'h208);
      @(negedge clk);
    end
    out_ready_a[0] = 1'b1;
    @(negedge clk);
    out_ready_a[0] = 1'b0;
    check("bp_rel_clr", 32'({out_valid_a[0], acc_clr_a[0], in_ready_a[0]}), 32'b010);
    @(negedge clk);
    check("bp_rel_rdy", 32'({out_valid_a[0], acc_clr_a[0], in_ready_a[0]}), 32'b001);

    // Overflow at MAX_TERMS=2, then a clean neuron 2*3+1 = 7
    send(1, 8'd1, 8'd1, 8'd0, 1'b0);
    send(1, 8'd1, 8'd1, 8'd0, 1'b0);
    send(1, 8'd1, 8'd1, 8'd0, 1'b1);
    result(1, "ovf", 8'd2, 2, 1'b1, 2);
    send(1, 8'd2, 8'd3, 8'd1, 1'b1);
    result(1, "post_ovf", 8'd7, 1, 1'b0, 1);

    // Reset after term 2 of 3 drops the neuron
    send(0, 8'd5, 8'd2, 8'd1, 1'b0);
    send(0, 8'd3, 8'd4, 8'd1, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 32'({acc_clr_a[0], out_valid_a[0], in_ready_a[0]}), 32'b100);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid_a[0]) seen = 1'b1;
      @(negedge clk);
    end
    check("mid_rst_noout", 32'(seen), 32'd0);
    send(0, 8'd5, 8'd2, 8'd1, 1'b1);
    result(0, "fresh", 8'd11, 1, 1'b0, 1);

    // SETUP_CYC=1 and 3 with input gaps: 2*3+4 + -2*4 + 7*1 = 9
    for (int k = 2; k < 4; k++) begin
      send(k, 8'd2, 8'd3, 8'd4, 1'b0);
      repeat (2) @(negedge clk);
      send(k, 8'hFE, 8'd4, 8'd4, 1'b0);
      repeat (4) @(negedge clk);
      send(k, 8'd7, 8'd1, 8'd4, 1'b1);
      result(k, (k == 2) ? "s1" : "s3", 8'd9, 3, 1'b0, 3);
    end

    for (int k = 0; k < NI; k++) begin
      check("stable_ops", 32'(stab_viol_a[k]), 32'd0);
      check("en_clr_overlap", 32'(ovl_viol_a[k]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
